rom_sequencer: RTL and testbench

- Reads the servo-motion ROM word by word.
- Holds each word's servo angles on its outputs for the word's time field, in ticks of 20 ms.
- Sits between the motion ROM and the three servo PWM generators.
- Owns the ROM address bus and drives the ROM's address input, which has a registered output and one-cycle read latency.

---
 rtl/rom_seq_pkg.sv | 27 ++
 rtl/rom_sequencer.sv | 136 +++++++++++++
 tb/tb_rom_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the servo-motion ROM sequencer.
//   state_t     : sequencer FSM states
//   *_MSB/*_LSB : field positions inside a 32-bit motion ROM word
package rom_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned SERVO_W = 8;
  localparam int unsigned TIME_W  = 8;

  localparam int unsigned SERVO1_MSB = 31;
  localparam int unsigned SERVO1_LSB = 24;
  localparam int unsigned SERVO2_MSB = 23;
  localparam int unsigned SERVO2_LSB = 16;
  localparam int unsigned SERVO3_MSB = 15;
  localparam int unsigned SERVO3_LSB = 8;
  localparam int unsigned TIME_MSB   = 7;
  localparam int unsigned TIME_LSB   = 0;

endpackage

// File: rtl/rom_sequencer.sv
// Steps through the servo-motion ROM, presenting each word's three servo
// angles for T * TICK_CYCLES clocks, where T is the word's time field.
// Ports:
//   CLK, RST_N        clock (rising edge), async active-low reset
//   start, stop       start pulse (ignored while busy), abort level (wins)
//   address           ROM address (ROM has registered output, 1-cycle latency)
//   DATOS             ROM word {servo1, servo2, servo3, time}
//   servo1..3         current angle targets
//   pos_valid         one-cycle pulse when new angles are latched
//   busy              high while a sequence is in progress
//   done              one-cycle pulse at sequence end or zero-time word
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter logic [7:0]  LAST_ADDR   = 8'd11,
  parameter logic        LOOP        = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  address,
  input  logic [31:0] DATOS,
  output logic [7:0]  servo1,
  output logic [7:0]  servo2,
  output logic [7:0]  servo3,
  output logic        pos_valid,
  output logic        busy,
  output logic        done
);

  // Wide enough to hold 255 * TICK_CYCLES without truncation.
  localparam int unsigned CNT_W = TIME_W + $clog2(TICK_CYCLES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  address_nxt;
  logic [SERVO_W-1:0] servo1_nxt, servo2_nxt, servo3_nxt;
  logic               pos_valid_nxt, busy_nxt, done_nxt;
  logic [TIME_W-1:0]  time_f;

  assign time_f = DATOS[TIME_MSB:TIME_LSB];

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      address   <= '0;
      servo1    <= '0;
      servo2    <= '0;
      servo3    <= '0;
      pos_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      address   <= address_nxt;
      servo1    <= servo1_nxt;
      servo2    <= servo2_nxt;
      servo3    <= servo3_nxt;
      pos_valid <= pos_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    address_nxt   = address;
    servo1_nxt    = servo1;
    servo2_nxt    = servo2;
    servo3_nxt    = servo3;
    pos_valid_nxt = 1'b0;
    done_nxt      = 1'b0;

    if (stop) begin
      // Abort: servos keep their last angles, no done pulse.
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            address_nxt = '0;
            state_nxt   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          state_nxt = ST_LATCH;
        end
        ST_LATCH: begin
          if (time_f != '0) begin
            servo1_nxt    = DATOS[SERVO1_MSB:SERVO1_LSB];
            servo2_nxt    = DATOS[SERVO2_MSB:SERVO2_LSB];
            servo3_nxt    = DATOS[SERVO3_MSB:SERVO3_LSB];
            pos_valid_nxt = 1'b1;
            // Counter reaching zero marks the last of T*TICK_CYCLES hold edges.
            cnt_nxt       = CNT_W'(time_f) * CNT_W'(TICK_CYCLES) - CNT_W'(1);
            state_nxt     = ST_HOLD;
          end else begin
            // Zero-time word is an end marker.
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            if (address != LAST_ADDR) begin
              address_nxt = address + ADDR_W'(1);
              state_nxt   = ST_WAIT;
            end else if (LOOP) begin
              address_nxt = '0;
              state_nxt   = ST_WAIT;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Randomized bench for rom_sequencer: two instances (one-shot and looping)
// share a behavioural ROM; expectations come from a per-word schedule.
module tb_rom_sequencer;

  localparam int unsigned TC    = 4;
  localparam int          N_MAX = 4000;

  typedef struct {
    logic [23:0] srv;
    logic [7:0]  addr;
    logic        chk_addr;
    logic        pv;
    logic        dn;
    logic        bsy;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N, start, stop;
  logic [31:0] rom_mem [0:255];
  logic [31:0] datos_a, datos_b;
  logic [7:0]  addr_a, addr_b;
  logic [7:0]  s1_a, s2_a, s3_a, s1_b, s2_b, s3_b;
  logic        pv_a, pv_b, bsy_a, bsy_b, dn_a, dn_b;

  exp_t        exp_q [2][N_MAX];
  logic [23:0] last_s [2];
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  // Motion ROM with registered output, one port per instance.
  always @(posedge CLK) begin
    datos_a <= rom_mem[addr_a];
    datos_b <= rom_mem[addr_b];
  end

  rom_sequencer #(.TICK_CYCLES(TC), .LAST_ADDR(8'd5), .LOOP(1'b0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .address(addr_a),
    .DATOS(datos_a), .servo1(s1_a), .servo2(s2_a), .servo3(s3_a),
    .pos_valid(pv_a), .busy(bsy_a), .done(dn_a));

  rom_sequencer #(.TICK_CYCLES(TC), .LAST_ADDR(8'd3), .LOOP(1'b1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .address(addr_b),
    .DATOS(datos_b), .servo1(s1_b), .servo2(s2_b), .servo3(s3_b),
    .pos_valid(pv_b), .busy(bsy_b), .done(dn_b));

  function automatic exp_t mk(logic [23:0] s, logic [7:0] a, logic c,
                              logic p, logic d, logic b);
    exp_t e;
    e.srv = s; e.addr = a; e.chk_addr = c; e.pv = p; e.dn = d; e.bsy = b;
    return e;
  endfunction

  // Window long enough for the one-shot instance to finish words 0..5.
  function automatic int est_win();
    int w;
    logic [31:0] word;
    w = 12;
    for (int a = 0; a < 6; a++) begin
      word = rom_mem[a];
      w += int'(word[7:0]) * int'(TC) + 2;
    end
    return (w > N_MAX) ? N_MAX : w;
  endfunction

  // Expected outputs after edge k+n, derived word by word from the ROM.
  task automatic build(input int d, input int n_win);
    int          t, n_fill, a, tend, last;
    bit          lp, fin;
    logic [23:0] cur;
    logic [31:0] w;
    last = (d == 0) ? 5 : 3;
    lp   = (d == 1);
    cur  = last_s[d];
    a = 0; t = 2; n_fill = 0; fin = 0;
    while (!fin && n_fill < n_win) begin
      w = rom_mem[a];
      for (int n = n_fill; n < t && n < n_win; n++)
        exp_q[d][n] = mk(cur, 8'(a), 1'b1, 1'b0, 1'b0, 1'b1);
      if (w[7:0] == 8'd0) begin
        for (int n = t; n < n_win; n++)
          exp_q[d][n] = mk(cur, 8'(a), 1'b1, 1'b0, n == t, 1'b0);
        fin = 1;
      end else begin
        cur  = w[31:8];
        tend = t + int'(w[7:0]) * int'(TC);
        for (int n = t; n < tend && n < n_win; n++)
          exp_q[d][n] = mk(cur, 8'(a), 1'b1, n == t, 1'b0, 1'b1);
        if (a == last && !lp) begin
          for (int n = tend; n < n_win; n++)
            exp_q[d][n] = mk(cur, 8'(a), 1'b1, 1'b0, n == tend, 1'b0);
          fin = 1;
        end else begin
          a = (a == last) ? 0 : a + 1;
          n_fill = tend;
          t = tend + 2;
        end
      end
    end
  endtask

  task automatic compare(input int d, input int n);
    logic [23:0] srv;
    logic [7:0]  ad;
    logic        pv, dn, bs;
    exp_t        e;
    e = exp_q[d][n];
    if (d == 0) begin
      srv = {s1_a, s2_a, s3_a}; ad = addr_a; pv = pv_a; dn = dn_a; bs = bsy_a;
    end else begin
      srv = {s1_b, s2_b, s3_b}; ad = addr_b; pv = pv_b; dn = dn_b; bs = bsy_b;
    end
    checks += 4;
    if (srv !== e.srv) begin
      failures++;
      $display("FAIL servos dut%0d cyc k+%0d got %h want %h", d, n, srv, e.srv);
    end
    if (pv !== e.pv) begin
      failures++;
      $display("FAIL pos_valid dut%0d cyc k+%0d got %b want %b", d, n, pv, e.pv);
    end
    if (dn !== e.dn) begin
      failures++;
      $display("FAIL done dut%0d cyc k+%0d got %b want %b", d, n, dn, e.dn);
    end
    if (bs !== e.bsy) begin
      failures++;
      $display("FAIL busy dut%0d cyc k+%0d got %b want %b", d, n, bs, e.bsy);
    end
    if (e.chk_addr) begin
      checks++;
      if (ad !== e.addr) begin
        failures++;
        $display("FAIL address dut%0d cyc k+%0d got %0d want %0d", d, n, ad, e.addr);
      end
    end
  endtask

  // Start at edge k, optionally stop at k+stop_at / re-pulse start at k+restart_at.
  task automatic run_window(input int n_win, input int stop_at, input int restart_at);
    build(0, n_win);
    build(1, n_win);
    if (stop_at > 0) begin
      for (int d = 0; d < 2; d++)
        for (int n = stop_at; n < n_win; n++)
          exp_q[d][n] = mk(exp_q[d][stop_at-1].srv, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge CLK);
    start = 1'b1;
    for (int n = 0; n < n_win; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      start = (n + 1 == restart_at);
      stop  = (n + 1 == stop_at);
      compare(0, n);
      compare(1, n);
    end
    // Park both instances in idle; stop wins over any pending latch.
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    last_s[0] = exp_q[0][n_win-1].srv;
    last_s[1] = exp_q[1][n_win-1].srv;
  endtask

  task automatic fill_rom(input int t_max);
    for (int a = 0; a < 256; a++) rom_mem[a] = 32'd0;
    for (int a = 0; a < 6; a++)
      rom_mem[a] = {24'($urandom()), 8'($urandom_range(t_max, 1))};
  endtask

  task automatic check_all_zero(input string tag);
    checks += 2;
    if ({addr_a, s1_a, s2_a, s3_a, pv_a, dn_a, bsy_a} !== 35'd0) begin
      failures++;
      $display("FAIL %s dut0 got %h want 0", tag, {addr_a, s1_a, s2_a, s3_a, pv_a, dn_a, bsy_a});
    end
    if ({addr_b, s1_b, s2_b, s3_b, pv_b, dn_b, bsy_b} !== 35'd0) begin
      failures++;
      $display("FAIL %s dut1 got %h want 0", tag, {addr_b, s1_b, s2_b, s3_b, pv_b, dn_b, bsy_b});
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset_values");
    RST_N = 1'b1;
    last_s[0] = 24'd0;
    last_s[1] = 24'd0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_sequence();
    for (int r = 0; r < 3; r++) begin
      fill_rom(6);
      run_window(est_win(), 0, 0);
    end
  endtask

  task automatic test_zero_word();
    fill_rom(5);
    rom_mem[3] = {24'($urandom()), 8'd0};
    run_window(est_win(), 0, 0);
  endtask

  task automatic test_loop();
    fill_rom(4);
    run_window(2 * est_win(), 0, 0);
  endtask

  task automatic test_long_time();
    fill_rom(3);
    rom_mem[0] = {24'($urandom()), 8'd255};
    run_window(est_win(), 0, 0);
  endtask

  task automatic test_stop();
    int w;
    fill_rom(6);
    w = est_win();
    run_window(w, $urandom_range(w / 2, 3), 0);
    fill_rom(6);
    run_window(est_win(), 0, 0);
  endtask

  task automatic test_back_to_back();
    fill_rom(6);
    run_window(est_win(), 0, 3);
  endtask

  task automatic test_reset_mid();
    fill_rom(6);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat ($urandom_range(20, 5)) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check_all_zero("start_in_reset");
    RST_N = 1'b1;
    last_s[0] = 24'd0;
    last_s[1] = 24'd0;
    @(negedge CLK);
    check_all_zero("after_release");
    run_window(est_win(), 0, 0);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_zero_word();
    test_loop();
    test_long_time();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
